// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite master: valid/ready request in, NONSEQ/SINGLE transfer out, one-cycle response strobe.
// Latency: accept edge T0, address phase T1, data phase T2, rsp_valid in T3; each HREADY=0 cycle adds one.
// Backpressure: req_ready is high only in IDLE (including the response cycle); slave waits stall via HREADY.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        misaligned;

    // Only single SINGLE, non-locked transfers are ever issued, so these never change.
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;

    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HTRANS    = htrans_q;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and output decode; illegal sizes and unaligned addresses are rejected without touching the bus.
    always_comb begin
        state_d     = state_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        htrans_d    = htrans_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        misaligned  = (req_size > 3'd2) ||
                      ((req_size == 3'd1) && req_addr[0]) ||
                      ((req_size == 3'd2) && (req_addr[1:0] != 2'b00));
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        haddr_d  = req_addr;
                        hwrite_d = req_write;
                        hsize_d  = req_size;
                        htrans_d = TRANS_NONSEQ;
                        wdata_d  = req_wdata;
                        state_d  = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                // Address phase completes when the (empty) previous data phase reports ready.
                if (HREADY) begin
                    htrans_d = TRANS_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : 32'h0;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                // First ERROR cycle has HREADY=0 and is treated as an ordinary wait.
                if (HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    rsp_rdata_d = (!hwrite_q && !HRESP) ? HRDATA : 32'h0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                htrans_d = TRANS_IDLE;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and bus registers; reset drops any transfer in flight without a response.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            haddr_q     <= 32'h0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            htrans_q    <= TRANS_IDLE;
            hwdata_q    <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
